// File: rtl/icache_refill.sv
// Instruction-cache refill responder: owns the backing instruction memory, reads a four-word
// line at MEM_LATENCY cycles per word, and writes it into the cache with a one-cycle strobe.
module icache_refill #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned MEM_WORDS   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ICacheMiss,
  input  logic [4:0]   ICacheMiss_tag,
  output logic         WiCache,
  output logic [127:0] WiCacheline,
  output logic [8:0]   WiCachetag,
  output logic         refill_busy,
  input  logic         pm_we,
  input  logic [4:0]   pm_addr,
  input  logic [31:0]  pm_wdata,
  output logic [7:0]   refill_cnt
);

  localparam logic [3:0] LatReload = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StFill, StHold} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [2:0]    r_tag;
  logic [1:0]    r_idx;
  logic [3:0]    r_lat;
  logic [31:0]   r_mem [MEM_WORDS];
  logic [95:0]   r_buf;
  logic [127:0]  r_line;
  logic [8:0]    r_tagw;
  logic [7:0]    r_cnt;
  logic [31:0]   w_rd_data;
  logic          w_capture;
  logic          w_last;

  assign w_rd_data = r_mem[{r_tag, r_idx}];
  assign w_capture = (r_state == StFetch) && (r_lat == 4'd0);
  assign w_last    = w_capture && (r_idx == 2'd3);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (ICacheMiss) w_state_next = StFetch;
      StFetch: if (w_last) w_state_next = StFill;
      StFill:  w_state_next = StHold;
      StHold:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_tag   <= 3'd0;
      r_idx   <= 2'd0;
      r_lat   <= 4'd0;
      r_buf   <= 96'd0;
      r_line  <= 128'd0;
      r_tagw  <= 9'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (ICacheMiss) begin
            r_tag <= ICacheMiss_tag[4:2];
            r_idx <= 2'd0;
            r_lat <= LatReload;
          end
        end
        StFetch: begin
          if (r_lat != 4'd0) begin
            r_lat <= r_lat - 4'd1;
          end else if (r_idx == 2'd3) begin
            // Publish the whole line at once so the outputs only change on entry to fill.
            r_line <= {w_rd_data, r_buf};
            r_tagw <= {1'b1, 3'b000, r_tag, 2'b01};
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          end else begin
            unique case (r_idx)
              2'd0:    r_buf[31:0]  <= w_rd_data;
              2'd1:    r_buf[63:32] <= w_rd_data;
              default: r_buf[95:64] <= w_rd_data;
            endcase
            r_idx <= r_idx + 2'd1;
            r_lat <= LatReload;
          end
        end
        default: ;
      endcase
    end
  end

  // Loader writes are independent of the refill FSM; same-edge capture sees the old word.
  always_ff @(posedge clk) begin
    if (pm_we) r_mem[pm_addr] <= pm_wdata;
  end

  assign WiCache     = (r_state == StFill);
  assign WiCacheline = r_line;
  assign WiCachetag  = r_tagw;
  assign refill_busy = (r_state != StIdle);
  assign refill_cnt  = r_cnt;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: default-latency and latency-1 instances share reset and loader.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss0, miss1;
  logic [4:0]   tag0, tag1;
  logic         pm_we;
  logic [4:0]   pm_addr;
  logic [31:0]  pm_wdata;
  logic         wic0, wic1, busy0, busy1;
  logic [127:0] line0, line1;
  logic [8:0]   tagw0, tagw1;
  logic [7:0]   cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_refill #(.MEM_LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .ICacheMiss(miss0), .ICacheMiss_tag(tag0),
    .WiCache(wic0), .WiCacheline(line0), .WiCachetag(tagw0), .refill_busy(busy0),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .refill_cnt(cnt0)
  );

  icache_refill #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .ICacheMiss(miss1), .ICacheMiss_tag(tag1),
    .WiCache(wic1), .WiCacheline(line1), .WiCachetag(tagw1), .refill_busy(busy1),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .refill_cnt(cnt1)
  );

  typedef struct {
    logic [4:0]   tag;
    logic [127:0] line;
    logic [8:0]   tagw;
    logic [7:0]   cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pm_we = 1'b1; pm_addr = a; pm_wdata = d;
    @(negedge clk);
    pm_we = 1'b0;
  endtask

  // Issues one miss and follows it until refill_busy drops. wr_edge=k drives a loader write
  // sampled on the k-th edge after the miss-sample edge (0 = no write).
  task automatic run_refill(input bit sel, input logic [4:0] t, input int wr_edge,
                            input logic [4:0] wa, input logic [31:0] wd,
                            output int lat, output int pulses, output int busy_cyc,
                            output logic [127:0] line, output logic [8:0] tw);
    bit w, b;
    lat = -1; pulses = 0; busy_cyc = 0; line = '0; tw = '0;
    @(negedge clk);
    if (sel) begin miss1 = 1'b1; tag1 = t; end
    else begin miss0 = 1'b1; tag0 = t; end
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      miss0 = 1'b0; miss1 = 1'b0;
      pm_we = (k == wr_edge); pm_addr = wa; pm_wdata = wd;
      w = sel ? wic1 : wic0;
      b = sel ? busy1 : busy0;
      if (w) begin
        if (lat < 0) begin
          lat  = k - 1;
          line = sel ? line1 : line0;
          tw   = sel ? tagw1 : tagw0;
        end
        pulses++;
      end
      if (b) busy_cyc++;
      if (!b && k > 1) break;
    end
    @(negedge clk);
    pm_we = 1'b0;
  endtask

  int           lat, pulses, busy_cyc, prev, bad_sp, npulse;
  logic [127:0] line;
  logic [8:0]   tw;

  initial begin
    rst = 1'b1; miss0 = 1'b0; miss1 = 1'b0; tag0 = '0; tag1 = '0;
    pm_we = 1'b0; pm_addr = '0; pm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wic0", 128'(wic0), 128'd0);
    chk("rst_line0", line0, 128'd0);
    chk("rst_tagw0", 128'(tagw0), 128'd0);
    chk("rst_busy0", 128'(busy0), 128'd0);
    chk("rst_cnt0", 128'(cnt0), 128'd0);
    chk("rst_wic1", 128'(wic1), 128'd0);
    chk("rst_busy1", 128'(busy1), 128'd0);
    chk("rst_cnt1", 128'(cnt1), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) mem_write(5'(i), 32'h1000_0000 + i);
    for (int i = 0; i < 4; i++) mem_write(5'(8 + i), 32'hA0 + i);

    vecs[0] = '{5'd9,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 9'h109, 8'd1};
    vecs[1] = '{5'd0,  {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                9'h101, 8'd2};
    vecs[2] = '{5'd22, {32'h1000_0017, 32'h1000_0016, 32'h1000_0015, 32'h1000_0014},
                9'h115, 8'd3};
    vecs[3] = '{5'd31, {32'h1000_001F, 32'h1000_001E, 32'h1000_001D, 32'h1000_001C},
                9'h11D, 8'd4};

    foreach (vecs[i]) begin
      run_refill(1'b0, vecs[i].tag, 0, 5'd0, 32'd0, lat, pulses, busy_cyc, line, tw);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'd8);
      chk($sformatf("v%0d_pulses", i), 128'(pulses), 128'd1);
      chk($sformatf("v%0d_busy", i), 128'(busy_cyc), 128'd10);
      chk($sformatf("v%0d_line", i), line, vecs[i].line);
      chk($sformatf("v%0d_tagw", i), 128'(tw), 128'(vecs[i].tagw));
      chk($sformatf("v%0d_cnt", i), 128'(cnt0), 128'(vecs[i].cnt));
      chk($sformatf("v%0d_hold_line", i), line0, vecs[i].line);
    end

    // Latency-1 instance, top line.
    run_refill(1'b1, 5'd31, 0, 5'd0, 32'd0, lat, pulses, busy_cyc, line, tw);
    chk("l1_latency", 128'(lat), 128'd4);
    chk("l1_pulses", 128'(pulses), 128'd1);
    chk("l1_busy", 128'(busy_cyc), 128'd6);
    chk("l1_line", line, vecs[3].line);
    chk("l1_tagw", 128'(tw), 128'h11D);
    chk("l1_cnt", 128'(cnt1), 128'd1);

    // Reset two cycles into fetch abandons the refill.
    @(negedge clk); miss0 = 1'b1; tag0 = 5'd9;
    @(posedge clk);
    @(negedge clk); miss0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wic0) pulses++;
    end
    chk("abort_pulses", 128'(pulses), 128'd0);
    chk("abort_busy", 128'(busy0), 128'd0);
    chk("abort_cnt", 128'(cnt0), 128'd0);
    chk("abort_line", line0, 128'd0);

    // Miss in the same cycle as reset is not sampled.
    rst = 1'b1; miss0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; miss0 = 1'b0;
    @(negedge clk);
    chk("rst_miss_busy", 128'(busy0), 128'd0);

    run_refill(1'b0, 5'd9, 0, 5'd0, 32'd0, lat, pulses, busy_cyc, line, tw);
    chk("post_rst_latency", 128'(lat), 128'd8);
    chk("post_rst_line", line, vecs[0].line);
    chk("post_rst_cnt", 128'(cnt0), 128'd1);

    // Loader write on the word-2 capture edge: the capture sees the old word.
    run_refill(1'b0, 5'd9, 6, 5'd10, 32'hDEAD, lat, pulses, busy_cyc, line, tw);
    chk("rbw_line", line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("rbw_cnt", 128'(cnt0), 128'd2);
    // Write to word 0 after its capture is not reflected in this refill.
    run_refill(1'b0, 5'd9, 4, 5'd8, 32'hBEEF, lat, pulses, busy_cyc, line, tw);
    chk("newdata_line", line, {32'hA3, 32'hDEAD, 32'hA1, 32'hA0});
    chk("newdata_tagw", 128'(tw), 128'h109);

    // Continuous miss on the latency-1 instance: spacing and counter saturation.
    @(negedge clk); miss1 = 1'b1; tag1 = 5'd4;
    prev = -1; bad_sp = 0; npulse = 0;
    for (int c = 0; c < 2600 && npulse < 300; c++) begin
      @(negedge clk);
      if (wic1) begin
        if (prev >= 0 && (c - prev) != 7) bad_sp++;
        prev = c;
        npulse++;
      end
    end
    miss1 = 1'b0;
    chk("stream_pulses", 128'(npulse), 128'd300);
    chk("stream_bad_spacing", 128'(bad_sp), 128'd0);
    chk("stream_cnt_sat", 128'(cnt1), 128'd255);
    chk("stream_tagw", 128'(tagw1), 128'h105);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
